// File: rtl/uart_pkg.sv
// Shared definitions for the UART framing stage.
// Holds the start-of-frame default, the error codes reported on err_code,
// the parser state encoding and the default inter-byte timeout, which is
// derived from the UART bit time.
package uart_pkg;

  // One UART bit time in system clocks: 27 MHz / 115200 baud, rounded down.
  localparam int CLK_HZ        = 27_000_000;
  localparam int BAUD_RATE     = 115_200;
  localparam int BAUD_TICKS    = CLK_HZ / BAUD_RATE;

  // Allowed silence between two bytes of one frame, as a number of bit times.
  localparam int TIMEOUT_BIT_TIMES      = 20;
  localparam int DEFAULT_TIMEOUT_CYCLES = TIMEOUT_BIT_TIMES * BAUD_TICKS;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // Values driven on err_code while err is high.
  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    WAIT_SOF    = 3'd0,
    GET_CMD     = 3'd1,
    GET_LEN     = 3'd2,
    GET_PAYLOAD = 3'd3,
    GET_CSUM    = 3'd4,
    HOLD        = 3'd5
  } parser_state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer.
// Counts idle clocks while enabled and raises expire combinationally once
// the count reaches TIMEOUT_CYCLES-1. A clear (a byte arriving) in the same
// cycle suppresses expire, so a late byte always wins over the timeout.
// The count saturates; the parser leaves the enabling states on expiry,
// which drops enable and keeps expire to a single cycle.
//
// Ports:
//   clock    system clock
//   n_reset  asynchronous active-low reset
//   clear    restart the gap count (a byte was received)
//   enable   count only while a frame is being assembled
//   expire   high for the cycle in which the gap limit is reached
module uart_gap_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 16'd1;
    end
  end

  assign expire = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// Byte-level frame parser sitting behind the UART receiver.
// Assembles frames SOF, CMD, LEN, PAYLOAD[LEN], CSUM where CSUM is the XOR
// of CMD, LEN and every payload byte. A good frame is held (frame_pending)
// until the consumer acks it; the payload is read through rd_addr/rd_data.
// Malformed frames produce a one-cycle err pulse with err_code.
//
// Ports:
//   clock, n_reset     system clock, asynchronous active-low reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   frame_valid        one-cycle pulse when a good frame is latched
//   frame_pending      high while a good frame is held awaiting frame_ack
//   frame_ack          consumer releases the held frame
//   frame_cmd          CMD byte of the held frame
//   frame_len          LEN byte of the held frame
//   rd_addr, rd_data   combinational payload read port
//   err, err_code      one-cycle error pulse and its cause
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int         ADDR_W         = $clog2(MAX_LEN)
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              frame_valid,
  output logic              frame_pending,
  input  logic              frame_ack,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t state;
  logic [7:0]    cmd_q;
  logic [7:0]    len_q;
  logic [7:0]    idx;
  logic [7:0]    csum;

  logic [7:0]        payload_buf [MAX_LEN];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  logic gap_en;
  logic gap_expire;

  // The gap timer only runs while a frame is partially received.
  assign gap_en = (state == GET_CMD) || (state == GET_LEN) ||
                  (state == GET_PAYLOAD) || (state == GET_CSUM);

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clock  (clock),
    .n_reset(n_reset),
    .clear  (rx_valid),
    .enable (gap_en),
    .expire (gap_expire)
  );

  // Payload storage. Writes happen only while collecting payload, so the
  // contents stay stable for the whole time a frame is held.
  assign wr_en   = (state == GET_PAYLOAD) && rx_valid;
  assign wr_addr = idx[ADDR_W-1:0];

  // NOTE: the payload array has no reset; every location read for a frame is
  // written by that frame first, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      payload_buf[wr_addr] <= rx_data;
    end
  end

  assign rd_data = payload_buf[rd_addr];

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the values from before this clock edge.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state         <= WAIT_SOF;
      cmd_q         <= '0;
      len_q         <= '0;
      idx           <= '0;
      csum          <= '0;
      frame_valid   <= 1'b0;
      frame_pending <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      err           <= 1'b0;
      err_code      <= '0;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;

      case (state)
        WAIT_SOF: begin
          if (rx_valid && (rx_data == SOF_BYTE)) begin
            csum  <= '0;
            state <= GET_CMD;
          end
        end

        GET_CMD: begin
          if (rx_valid) begin
            cmd_q <= rx_data;
            csum  <= csum ^ rx_data;
            state <= GET_LEN;
          end
        end

        GET_LEN: begin
          if (rx_valid) begin
            if (rx_data > MAX_LEN_B) begin
              err      <= 1'b1;
              err_code <= ERR_LEN;
              state    <= WAIT_SOF;
            end else begin
              len_q <= rx_data;
              idx   <= '0;
              csum  <= csum ^ rx_data;
              state <= (rx_data == 8'd0) ? GET_CSUM : GET_PAYLOAD;
            end
          end
        end

        GET_PAYLOAD: begin
          if (rx_valid) begin
            csum <= csum ^ rx_data;
            idx  <= idx + 8'd1;
            if (idx == (len_q - 8'd1)) begin
              state <= GET_CSUM;
            end
          end
        end

        GET_CSUM: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              frame_valid   <= 1'b1;
              frame_pending <= 1'b1;
              frame_cmd     <= cmd_q;
              frame_len     <= len_q;
              state         <= HOLD;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_CSUM;
              state    <= WAIT_SOF;
            end
          end
        end

        HOLD: begin
          if (frame_ack) begin
            // The ack frees the buffer this cycle, so a byte arriving with it
            // is treated exactly as if we were already waiting for SOF.
            frame_pending <= 1'b0;
            if (rx_valid && (rx_data == SOF_BYTE)) begin
              csum  <= '0;
              state <= GET_CMD;
            end else begin
              state <= WAIT_SOF;
            end
          end else if (rx_valid) begin
            err      <= 1'b1;
            err_code <= ERR_OVERRUN;
          end
        end

        default: state <= WAIT_SOF;
      endcase

      // Expiry is already masked by a same-cycle byte and by the state, so
      // this never collides with another error above.
      if (gap_expire) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state    <= WAIT_SOF;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed testbench for uart_frame_parser.
// Bytes are driven on the falling edge and outputs are sampled on the
// falling edge; a monitor on the rising edge counts err and frame_valid
// pulses so each scenario can confirm that nothing unexpected fired.
module tb_uart_frame_parser;

  localparam int TIMEOUT = 4680;

  logic       clock = 1'b0;
  logic       n_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_valid;
  logic       frame_pending;
  logic       frame_ack;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  int err_seen = 0;
  int fv_seen  = 0;

  logic [7:0] tx_q [$];

  uart_frame_parser dut (
    .clock        (clock),
    .n_reset      (n_reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_valid  (frame_valid),
    .frame_pending(frame_pending),
    .frame_ack    (frame_ack),
    .frame_cmd    (frame_cmd),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clock = ~clock;

  // Count pulses seen during the cycle that ends at this rising edge.
  always @(posedge clock) begin
    if (err === 1'b1) err_seen <= err_seen + 1;
    if (frame_valid === 1'b1) fv_seen <= fv_seen + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, limit reached", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic put(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
  endtask

  // Sends every queued byte back to back, then leaves the line idle. On
  // return the outputs reflect the last byte.
  task automatic send_q();
    while (tx_q.size() > 0) put(tx_q.pop_front());
    idle(1);
  endtask

  task automatic ack();
    @(negedge clock);
    frame_ack = 1'b1;
    @(negedge clock);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_reset   = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    frame_ack = 1'b0;
    rd_addr   = 4'd0;
    repeat (3) @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
    total++;
    if ({frame_valid, frame_pending} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags: valid/pending got=%b want=00", {frame_valid, frame_pending});
    end
    total++;
    if ({frame_cmd, frame_len} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_cmd_len: got=%h want=0000", {frame_cmd, frame_len});
    end
    total++;
    if ({err, err_code} !== 3'b000) begin
      bad++;
      $display("FAIL reset_err: got=%b want=000", {err, err_code});
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp_pl [3] = '{8'h01, 8'h02, 8'h03};
    int e0 = err_seen;
    int f0 = fv_seen;
    tx_q = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13};
    send_q();
    total++;
    if ({frame_valid, frame_pending} !== 2'b11) begin
      bad++;
      $display("FAIL good_latch: valid/pending got=%b want=11", {frame_valid, frame_pending});
    end
    total++;
    if (frame_cmd !== 8'h10 || frame_len !== 8'h03) begin
      bad++;
      $display("FAIL good_cmd_len: got cmd=%h len=%h want cmd=10 len=03", frame_cmd, frame_len);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      #1;
      total++;
      if (rd_data !== exp_pl[i]) begin
        bad++;
        $display("FAIL good_payload[%0d]: got=%h want=%h", i, rd_data, exp_pl[i]);
      end
    end
    idle(3);
    total++;
    if ({frame_valid, frame_pending} !== 2'b01) begin
      bad++;
      $display("FAIL good_hold: valid/pending got=%b want=01", {frame_valid, frame_pending});
    end
    total++;
    if (fv_seen - f0 !== 1 || err_seen - e0 !== 0) begin
      bad++;
      $display("FAIL good_pulses: valid pulses=%0d err pulses=%0d want 1 and 0", fv_seen - f0, err_seen - e0);
    end
    ack();
    total++;
    if (frame_pending !== 1'b0) begin
      bad++;
      $display("FAIL good_ack: pending got=%b want=0", frame_pending);
    end
  endtask

  task automatic test_bad_csum();
    int f0 = fv_seen;
    tx_q = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14};
    send_q();
    total++;
    if ({err, err_code, frame_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL csum_err: err/code/valid got=%b want=1_00_0", {err, err_code, frame_valid});
    end
    idle(2);
    total++;
    if (fv_seen !== f0 || frame_pending !== 1'b0) begin
      bad++;
      $display("FAIL csum_no_frame: valid pulses=%0d pending=%b want 0 and 0", fv_seen - f0, frame_pending);
    end
    tx_q = '{8'hA5, 8'h20, 8'h00, 8'h20};
    send_q();
    total++;
    if (frame_valid !== 1'b1 || frame_cmd !== 8'h20 || frame_len !== 8'h00) begin
      bad++;
      $display("FAIL csum_zero_len: valid=%b cmd=%h len=%h want 1 20 00", frame_valid, frame_cmd, frame_len);
    end
    ack();
  endtask

  task automatic test_len_overflow();
    int e0 = err_seen;
    tx_q = '{8'hA5, 8'h10, 8'h11};
    send_q();
    total++;
    if ({err, err_code} !== 3'b101) begin
      bad++;
      $display("FAIL len_err: err/code got=%b want=1_01", {err, err_code});
    end
    // Full-size frame right afterwards: LEN equals the maximum of 16.
    tx_q = '{8'hA5, 8'h30, 8'h10};
    for (int i = 0; i < 16; i++) tx_q.push_back(8'h40 + 8'(i));
    tx_q.push_back(8'h20);
    send_q();
    total++;
    if (frame_valid !== 1'b1 || frame_cmd !== 8'h30 || frame_len !== 8'h10) begin
      bad++;
      $display("FAIL len_max_frame: valid=%b cmd=%h len=%h want 1 30 10", frame_valid, frame_cmd, frame_len);
    end
    rd_addr = 4'd0;
    #1;
    total++;
    if (rd_data !== 8'h40) begin
      bad++;
      $display("FAIL len_max_first: got=%h want=40", rd_data);
    end
    rd_addr = 4'd15;
    #1;
    total++;
    if (rd_data !== 8'h4F) begin
      bad++;
      $display("FAIL len_max_last: got=%h want=4f", rd_data);
    end
    idle(1);
    total++;
    if (err_seen - e0 !== 1) begin
      bad++;
      $display("FAIL len_err_count: err pulses=%0d want=1", err_seen - e0);
    end
    ack();
  endtask

  task automatic test_timeout();
    int         first = -1;
    logic [1:0] code  = 2'b00;
    int         e0;
    tx_q = '{8'hA5, 8'h10};
    send_q();
    // Counting idle falling edges from here, the error must first be visible
    // after exactly TIMEOUT silent cycles.
    for (int i = 1; i <= TIMEOUT + 4; i++) begin
      @(negedge clock);
      if (err === 1'b1 && first < 0) begin
        first = i;
        code  = err_code;
      end
    end
    total++;
    if (first !== TIMEOUT || code !== 2'd2) begin
      bad++;
      $display("FAIL timeout_expiry: first err at idle cycle %0d code=%0d want %0d code=2", first, code, TIMEOUT);
    end
    tx_q = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13};
    send_q();
    total++;
    if (frame_valid !== 1'b1 || frame_len !== 8'h03) begin
      bad++;
      $display("FAIL timeout_recover: valid=%b len=%h want 1 03", frame_valid, frame_len);
    end
    ack();

    // A byte landing in the very cycle the timer expires must win.
    tx_q = '{8'hA5, 8'h10};
    send_q();
    e0 = err_seen;
    repeat (TIMEOUT - 2) @(negedge clock);
    tx_q = '{8'h01, 8'h77, 8'h66};
    send_q();
    total++;
    if (frame_valid !== 1'b1 || frame_len !== 8'h01) begin
      bad++;
      $display("FAIL timeout_edge_frame: valid=%b len=%h want 1 01", frame_valid, frame_len);
    end
    rd_addr = 4'd0;
    #1;
    total++;
    if (rd_data !== 8'h77) begin
      bad++;
      $display("FAIL timeout_edge_payload: got=%h want=77", rd_data);
    end
    idle(2);
    total++;
    if (err_seen !== e0) begin
      bad++;
      $display("FAIL timeout_edge_noerr: err pulses=%0d want=0", err_seen - e0);
    end
    ack();
  endtask

  task automatic test_overrun_ack();
    int e0;
    tx_q = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13};
    send_q();
    e0 = err_seen;
    put(8'h55);
    idle(1);
    total++;
    if ({err, err_code} !== 3'b111) begin
      bad++;
      $display("FAIL overrun_err: err/code got=%b want=1_11", {err, err_code});
    end
    rd_addr = 4'd1;
    #1;
    total++;
    if (frame_pending !== 1'b1 || frame_cmd !== 8'h10 || frame_len !== 8'h03 || rd_data !== 8'h02) begin
      bad++;
      $display("FAIL overrun_held: pending=%b cmd=%h len=%h rd1=%h want 1 10 03 02",
               frame_pending, frame_cmd, frame_len, rd_data);
    end
    // Ack together with SOF: frame released, new frame starts, no error.
    @(negedge clock);
    frame_ack = 1'b1;
    rx_data   = 8'hA5;
    rx_valid  = 1'b1;
    @(negedge clock);
    frame_ack = 1'b0;
    rx_valid  = 1'b0;
    total++;
    if (frame_pending !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL ack_with_sof: pending=%b err=%b want 0 0", frame_pending, err);
    end
    tx_q = '{8'h40, 8'h01, 8'h99, 8'hD8};
    send_q();
    rd_addr = 4'd0;
    #1;
    total++;
    if (frame_valid !== 1'b1 || frame_cmd !== 8'h40 || frame_len !== 8'h01 || rd_data !== 8'h99) begin
      bad++;
      $display("FAIL ack_next_frame: valid=%b cmd=%h len=%h rd0=%h want 1 40 01 99",
               frame_valid, frame_cmd, frame_len, rd_data);
    end
    idle(1);
    total++;
    if (err_seen - e0 !== 1) begin
      bad++;
      $display("FAIL overrun_err_count: err pulses=%0d want=1", err_seen - e0);
    end
    ack();
  endtask

  task automatic test_noise();
    int e0 = err_seen;
    // A stray ack outside HOLD has no effect.
    ack();
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13};
    send_q();
    total++;
    if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || frame_len !== 8'h03) begin
      bad++;
      $display("FAIL noise_frame: valid=%b cmd=%h len=%h want 1 10 03", frame_valid, frame_cmd, frame_len);
    end
    idle(1);
    total++;
    if (err_seen !== e0) begin
      bad++;
      $display("FAIL noise_noerr: err pulses=%0d want=0", err_seen - e0);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    int e0;
    int f0;
    tx_q = '{8'hA5, 8'h10, 8'h03, 8'h01};
    send_q();
    e0 = err_seen;
    #2;
    n_reset = 1'b0;
    #1;
    total++;
    if ({frame_valid, frame_pending, err, err_code, frame_cmd, frame_len} !== 21'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: valid=%b pending=%b err=%b code=%b cmd=%h len=%h want all 0",
               frame_valid, frame_pending, err, err_code, frame_cmd, frame_len);
    end
    @(negedge clock);
    n_reset = 1'b1;
    f0 = fv_seen;
    tx_q = '{8'hA5, 8'h20, 8'h00, 8'h20};
    send_q();
    total++;
    if (frame_valid !== 1'b1 || frame_cmd !== 8'h20 || frame_len !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_restart: valid=%b cmd=%h len=%h want 1 20 00", frame_valid, frame_cmd, frame_len);
    end
    idle(1);
    total++;
    if (err_seen !== e0 || fv_seen - f0 !== 1) begin
      bad++;
      $display("FAIL reset_mid_pulses: err pulses=%0d valid pulses=%0d want 0 and 1", err_seen - e0, fv_seen - f0);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_overflow();
    test_timeout();
    test_overrun_ack();
    test_noise();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Byte-level framing stage directly downstream of the UART receiver. It consumes received bytes and their one-cycle ready strobe, then assembles frames of the form SOF, CMD, LEN, PAYLOAD[LEN], CSUM. Good frames are buffered and held for the host-side logic with a pending/ack handshake; malformed frames produce an error pulse with a code.

Parameters:
MAX_LEN, 16, maximum payload bytes; payload buffer depth.
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYCLES, 4680, allowed clock cycles between bytes inside a frame (~20 bit-times at 27 MHz / 115200).
ADDR_W, $clog2(MAX_LEN), payload read-address width.

Ports:
clock  in  1  system clock
n_reset  in  1  asynchronous active-low reset
rx_data  in  8  received byte; valid only while rx_valid=1
rx_valid  in  1  one-cycle strobe from the receiver
frame_valid  out  1  one-cycle pulse when a good frame is latched
frame_pending  out  1  high while a good frame is held, awaiting ack
frame_ack  in  1  consumer releases the held frame
frame_cmd  out  8  CMD byte of the held frame
frame_len  out  8  LEN of the held frame
rd_addr  in  ADDR_W  payload read index
rd_data  out  8  combinational read: buffer[rd_addr]
err  out  1  one-cycle error pulse
err_code  out  2  0=checksum, 1=bad length, 2=timeout, 3=overrun; meaningful only when err=1

Behaviour:
- Reset: single clock `clock`; asynchronous active-low reset `n_reset`. All outputs and registers clear to 0. State goes to WAIT_SOF. Buffer contents need not be cleared.
- Bytes are sampled only on cycles where rx_valid=1; rx_data is ignored otherwise.
- States: WAIT_SOF, GET_CMD, GET_LEN, GET_PAYLOAD, GET_CSUM, HOLD.
- WAIT_SOF:
  - byte==SOF_BYTE -> GET_CMD, and the running checksum clears to 0.
  - Any other byte is discarded silently.
- GET_CMD: store cmd; csum ^= byte; -> GET_LEN.
- GET_LEN:
  - byte > MAX_LEN -> err pulse code 1, -> WAIT_SOF.
  - byte==0 -> GET_CSUM.
  - Otherwise store len, clear the byte index, -> GET_PAYLOAD. In every accepted case csum ^= byte.
- GET_PAYLOAD: buffer[idx] <= byte; csum ^= byte; idx++. When idx==len-1 the state moves to GET_CSUM.
- GET_CSUM:
  - byte==csum -> HOLD, with frame_valid pulsed on the following cycle.
  - Otherwise err pulse code 0, -> WAIT_SOF.
- Checksum is the 8-bit XOR of CMD, LEN and all payload bytes. SOF is excluded.
- Latency: frame_valid and frame_pending rise in the cycle after the CSUM byte's rx_valid. err pulses in the cycle after the offending byte.
- HOLD:
  - frame_pending=1; frame_cmd, frame_len and the buffer are stable.
  - frame_ack=1 -> WAIT_SOF next cycle, and frame_pending drops the same edge.
  - rx_valid without ack -> byte dropped, err code 3.
  - rx_valid and frame_ack in the same cycle -> the ack wins and the byte is evaluated as in WAIT_SOF (may start the next frame). No error.
- frame_ack outside HOLD is ignored.
- Timeout:
  - The gap counter (16-bit) clears on every rx_valid and runs only in GET_CMD..GET_CSUM.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte: err code 2, -> WAIT_SOF.
  - A byte arriving in the same cycle as expiry wins, and no timeout occurs.
- Only one err pulse is generated per cycle.
- frame_cmd and frame_len update only on entry to HOLD; they do not change mid-frame.
- Reset asserted mid-frame aborts immediately. No err is generated.
- rd_addr >= frame_len returns stale buffer content. The consumer is responsible for range.

Decomposition:
- Shared package uart_pkg holds:
  - SOF default.
  - Error code localparams ERR_CSUM, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN.
  - Parser state encodings.
  - The BAUD_TICKS-derived default for TIMEOUT_CYCLES.
- One natural sub-module: uart_gap_timer. It contains the inter-byte counter with clear/enable inputs and a one-cycle expire output.
- The payload buffer stays inline as a register array.

Test Plan:
- Good frame: A5 10 03 01 02 03 13 -> frame_valid pulse; cmd=0x10, len=3, rd_data[0..2]=01,02,03; frame_pending=1 until ack.
- Bad checksum: A5 10 03 01 02 03 14 -> err=1 code 0, no frame_valid; next A5 20 00 20 -> frame_valid with len=0, cmd=0x20.
- Length overflow: A5 10 11 (17 > MAX_LEN 16) -> err code 1 after the LEN byte; a following valid frame is accepted normally.
- Timeout: A5 10 then idle 4680 cycles -> err code 2 exactly at expiry; next frame parses correctly. A byte at cycle 4679 -> no error.
- Overrun/ack: hold a good frame, send 0x55 without ack -> err code 3 and held data unchanged. Then send ack together with A5 -> no error, new frame begins.
- Noise: 00 FF 5A before a good frame -> silently discarded, frame accepted; async reset mid-payload -> all outputs 0, no err.
